// File: rtl/rr_arb_mux_n_pkg.sv
// ============================================================================
// rr_arb_mux_n_pkg : shared types and helpers for the round-robin arbiter mux
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb_mux_n_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_mux_n_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational rotating-mask round-robin priority encoder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import rr_arb_mux_n_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_IN-1:0] gnt_oh,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [NUM_IN-1:0] w_mask;
  logic [NUM_IN-1:0] w_hi;
  logic [NUM_IN-1:0] w_sel;
  logic [NUM_IN-1:0] w_oh;

  // Requests at or above ptr win; otherwise fall back to the lowest request.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_mask[i] = (i >= int'(ptr));
    end
    w_hi  = req & w_mask;
    w_sel = (|w_hi) ? w_hi : req;
    w_oh  = w_sel & (~w_sel + NUM_IN'(1));
  end

  always_comb begin
    gnt_oh  = en ? w_oh : '0;
    gnt_vld = en & (|req);
    gnt_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_oh[i]) gnt_idx = SEL_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux_n.sv
// ============================================================================
// rr_arb_mux_n : N-input registered round-robin arbitrating valid/ready mux.
// Optional packet lock enabled by defining ARB_MUX_PKT_LOCK_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_mux_n
  import rr_arb_mux_n_pkg::*;
#(
  parameter int  WIDTH  = 64,
  parameter int  NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
`ifdef ARB_MUX_PKT_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
`endif
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_src;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic              w_load_en;
  logic              w_xfer;
  logic              w_last;
  logic              w_gnt_vld;
  logic [NUM_IN-1:0] w_req;
  logic [NUM_IN-1:0] w_gnt_oh;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic [SEL_W-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0]  w_sel_data;

  assign w_load_en = ~r_out_valid | out_ready;

`ifdef ARB_MUX_PKT_LOCK_EN
  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [SEL_W-1:0] r_lock_ch;

  // While a packet is in flight only its owner may request.
  always_comb begin
    w_req = in_valid;
    if (r_state == ARB_LOCKED) w_req = in_valid & (NUM_IN'(1) << r_lock_ch);
  end

  assign w_last = |(in_last & w_gnt_oh);

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) w_state_nxt = w_last ? ARB_IDLE : ARB_LOCKED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_lock_ch <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer && r_state == ARB_IDLE) r_lock_ch <= w_gnt_idx;
    end
  end
`else
  assign w_req  = in_valid;
  assign w_last = 1'b1;
`endif

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (w_req),
    .ptr     (r_rr_ptr),
    .en      (w_load_en & ~rst),
    .gnt_oh  (w_gnt_oh),
    .gnt_idx (w_gnt_idx),
    .gnt_vld (w_gnt_vld)
  );

  assign in_ready = w_gnt_oh;
  assign w_xfer   = w_gnt_vld;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt_oh[i]}});
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + SEL_W'(1);

  // Pointer only moves past a channel once its packet (or single beat) is done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_load_en) begin
        r_out_valid <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_sel_data;
          r_out_src  <= w_gnt_idx;
        end
      end
      if (w_xfer && w_last) r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

`default_nettype wire
